pattern_stepper: RTL

- Generates the pattern-ROM read address from a sequence number and a step index.
- Sits between the pushbutton debouncers/throttle and the pattern ROM.
- Debounced up/down buttons select the sequence, with auto-repeat when held; a one-cycle step tick from the throttle advances the step within the sequence.
- Also exports seq_num and step_num for the HEX display logic.

---
 rtl/kros_pkg.sv | 26 ++
 rtl/press_repeater.sv | 109 ++++++++++
 rtl/pattern_stepper.sv | 117 +++++++++++
 3 files changed

// File: rtl/kros_pkg.sv
// Shared definitions for the pattern stepper: index widths, ROM address
// width, the press-repeater state encoding and a counter-width helper.
package kros_pkg;

    localparam int SEQ_BITS  = 6;
    localparam int STEP_BITS = 4;
    localparam int ADDR_W    = SEQ_BITS + STEP_BITS;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_HOLD   = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    // Width of a counter that has to hold values up to max(hold, repeat)-1.
    // Never narrower than one bit, so tiny simulation settings still elaborate.
    function automatic int cnt_width(input int hold_cyc, input int repeat_cyc);
        int m;
        m = (hold_cyc > repeat_cyc) ? hold_cyc : repeat_cyc;
        if (m < 2) begin
            return 1;
        end
        return $clog2(m);
    endfunction

endpackage

// File: rtl/press_repeater.sv
// Press detector with auto-repeat for one debounced, active-low pushbutton.
// Emits a one-cycle event on the press, again after the button has been
// held for HOLD_CYC cycles, and then every REPEAT_CYC cycles while held.
module press_repeater
    import kros_pkg::*;
#(
    parameter int HOLD_CYC   = 25000000,
    parameter int REPEAT_CYC = 5000000
) (
    input  logic CLK_50,
    input  logic reset_n,
    input  logic pb_n,
    output logic evt
);

    localparam int               CNT_W       = cnt_width(HOLD_CYC, REPEAT_CYC);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);

    rpt_state_t       state_q;
    rpt_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             evt_q;
    logic             evt_d;

    // pb_hist_q is the previous sample (released after reset). armed_q only
    // sets once the button has been seen released, so a button held across
    // reset cannot look like a fresh 1->0 edge when reset lets go.
    logic pb_hist_q;
    logic armed_q;
    logic pressed;
    logic fall;

    assign pressed = ~pb_n;
    assign fall    = armed_q & pb_hist_q & ~pb_n;
    assign evt     = evt_q;

    // Button history and arming flag.
    always_ff @(posedge CLK_50 or negedge reset_n) begin
        if (!reset_n) begin
            pb_hist_q <= 1'b1;
            armed_q   <= 1'b0;
        end else begin
            pb_hist_q <= pb_n;
            if (pb_n) begin
                armed_q <= 1'b1;
            end
        end
    end

    // Repeat FSM state, hold/repeat counter and registered event output.
    always_ff @(posedge CLK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RPT_IDLE;
            cnt_q   <= '0;
            evt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            evt_q   <= evt_d;
        end
    end

    // Next state: press starts the hold timer, hold expiry starts repeating,
    // any release drops straight back to idle without an event.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        evt_d   = 1'b0;
        case (state_q)
            RPT_IDLE: begin
                if (fall) begin
                    evt_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = RPT_HOLD;
                end
            end
            RPT_HOLD: begin
                if (!pressed) begin
                    cnt_d   = '0;
                    state_d = RPT_IDLE;
                end else if (cnt_q == HOLD_LAST) begin
                    evt_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = RPT_REPEAT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RPT_REPEAT: begin
                if (!pressed) begin
                    cnt_d   = '0;
                    state_d = RPT_IDLE;
                end else if (cnt_q == REPEAT_LAST) begin
                    evt_d = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = RPT_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/pattern_stepper.sv
// Pattern-ROM address generator: up/down buttons (with auto-repeat) pick the
// sequence, the throttle tick walks the step within it, and the combined
// {sequence, step} is re-registered as the ROM read address.
module pattern_stepper
    import kros_pkg::*;
#(
    parameter int HOLD_CYC   = 25000000,
    parameter int REPEAT_CYC = 5000000,
    parameter int STEP_LAST  = 15
) (
    input  logic                 CLK_50,
    input  logic                 reset_n,
    input  logic                 step_tick,
    input  logic                 run_en,
    input  logic                 pb_seq_up,
    input  logic                 pb_seq_dn,
    output logic [ADDR_W-1:0]    rom_addr,
    output logic [SEQ_BITS-1:0]  seq_num,
    output logic [STEP_BITS-1:0] step_num,
    output logic                 wrap_pulse
);

    localparam logic [STEP_BITS-1:0] STEP_LAST_V = STEP_BITS'(STEP_LAST);

    // Sequence index moves by one in either direction; the natural
    // SEQ_BITS-wide overflow gives the 63->0 and 0->63 wrap.
    function automatic logic [SEQ_BITS-1:0] seq_next(input logic [SEQ_BITS-1:0] cur,
                                                     input logic                up);
        return up ? (cur + 1'b1) : (cur - 1'b1);
    endfunction

    // Step index advances and returns to zero after STEP_LAST.
    function automatic logic [STEP_BITS-1:0] step_next(input logic [STEP_BITS-1:0] cur);
        return (cur == STEP_LAST_V) ? '0 : (cur + 1'b1);
    endfunction

    logic                 ev_up;
    logic                 ev_dn;
    logic                 seq_chg;

    logic [SEQ_BITS-1:0]  seq_d;
    logic [STEP_BITS-1:0] step_d;
    logic                 wrap_d;

    logic [SEQ_BITS-1:0]  seq_p0;
    logic [STEP_BITS-1:0] step_p0;
    logic                 wrap_p0;
    logic [ADDR_W-1:0]    rom_addr_p1;

    press_repeater #(
        .HOLD_CYC   (HOLD_CYC),
        .REPEAT_CYC (REPEAT_CYC)
    ) u_rpt_up (
        .CLK_50  (CLK_50),
        .reset_n (reset_n),
        .pb_n    (pb_seq_up),
        .evt     (ev_up)
    );

    press_repeater #(
        .HOLD_CYC   (HOLD_CYC),
        .REPEAT_CYC (REPEAT_CYC)
    ) u_rpt_dn (
        .CLK_50  (CLK_50),
        .reset_n (reset_n),
        .pb_n    (pb_seq_dn),
        .evt     (ev_dn)
    );

    // Opposing events in the same cycle cancel, so only a lone event counts.
    assign seq_chg = ev_up ^ ev_dn;

    // Counter next state: a sequence change wins over a coincident tick,
    // restarts the step at zero and suppresses the wrap pulse.
    always_comb begin
        seq_d  = seq_p0;
        step_d = step_p0;
        wrap_d = 1'b0;
        if (seq_chg) begin
            seq_d  = seq_next(seq_p0, ev_up);
            step_d = '0;
        end else if (step_tick && run_en) begin
            step_d = step_next(step_p0);
            wrap_d = (step_p0 == STEP_LAST_V);
        end
    end

    // ---- stage p0: sequence/step counters and wrap strobe ----
    // Counter registers.
    always_ff @(posedge CLK_50 or negedge reset_n) begin
        if (!reset_n) begin
            seq_p0  <= '0;
            step_p0 <= '0;
            wrap_p0 <= 1'b0;
        end else begin
            seq_p0  <= seq_d;
            step_p0 <= step_d;
            wrap_p0 <= wrap_d;
        end
    end

    // ---- stage p1: ROM address register, one cycle behind the counters ----
    // Address register so the ROM sees a clean, glitch-free address.
    always_ff @(posedge CLK_50 or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr_p1 <= '0;
        end else begin
            rom_addr_p1 <= {seq_p0, step_p0};
        end
    end

    assign seq_num    = seq_p0;
    assign step_num   = step_p0;
    assign wrap_pulse = wrap_p0;
    assign rom_addr   = rom_addr_p1;

endmodule
